// File: rtl/uart_tx_framer.sv
// uart_tx_framer: 8N1 UART transmitter with a synchronized flow-control input.
// Rev 1.0
`default_nettype none

module uart_tx_framer #(
  parameter int CLK_PER_BIT = 50,
  parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       new_data,
  input  logic       block,
  output logic       busy,
  output logic       tx
);

  localparam logic [CTR_SIZE-1:0] CTR_LAST = CTR_SIZE'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA      = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [CTR_SIZE-1:0] ctr, ctr_n;
  logic [2:0]          idx, idx_n;
  logic [7:0]          shreg, shreg_n;
  logic                tx_n, busy_n;
  logic                block_meta, block_s;
  logic                bit_done;

  assign bit_done = (ctr == CTR_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ctr        <= '0;
      idx        <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      block_meta <= 1'b0;
      block_s    <= 1'b0;
    end else begin
      state      <= state_n;
      ctr        <= ctr_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      tx         <= tx_n;
      busy       <= busy_n;
      block_meta <= block;
      block_s    <= block_meta;
    end
  end

  always_comb begin
    state_n = state;
    ctr_n   = ctr;
    idx_n   = idx;
    shreg_n = shreg;
    tx_n    = tx;
    busy_n  = busy;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = block_s;
        // busy was low this cycle, so the upstream gate cannot issue twice
        if (!busy && !block_s && new_data) begin
          state_n = START_BIT;
          shreg_n = data;
          ctr_n   = '0;
          idx_n   = '0;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START_BIT: begin
        tx_n   = 1'b0;
        busy_n = 1'b1;
        if (bit_done) begin
          ctr_n   = '0;
          state_n = DATA;
          tx_n    = shreg[0];
          shreg_n = {1'b0, shreg[7:1]};
        end else begin
          ctr_n = ctr + 1'b1;
        end
      end
      DATA: begin
        busy_n = 1'b1;
        if (bit_done) begin
          ctr_n = '0;
          if (idx == 3'd7) begin
            state_n = STOP_BIT;
            tx_n    = 1'b1;
          end else begin
            idx_n   = idx + 3'd1;
            tx_n    = shreg[0];
            shreg_n = {1'b0, shreg[7:1]};
          end
        end else begin
          ctr_n = ctr + 1'b1;
        end
      end
      STOP_BIT: begin
        tx_n   = 1'b1;
        busy_n = 1'b1;
        if (bit_done) begin
          ctr_n   = '0;
          state_n = IDLE;
          busy_n  = block_s;
        end else begin
          ctr_n = ctr + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        ctr_n   = '0;
        idx_n   = '0;
        tx_n    = 1'b1;
        busy_n  = block_s;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer: directed scenarios plus random traffic against a cycle-indexed frame model.
`default_nettype none

module tb_uart_tx_framer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       new_data;
  logic       block;
  logic       busy;
  logic       tx;

  always #5 clk = ~clk;

  uart_tx_framer #(.CLK_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .new_data (new_data),
    .block    (block),
    .busy     (busy),
    .tx       (tx)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: a frame accepted in cycle m_n drives bit (c-m_n-1)/CPB of {stop,data,start} in cycle c.
  logic       m_tx     = 1'b1;
  logic       m_busy   = 1'b0;
  logic       m_meta   = 1'b0;
  logic       m_s      = 1'b0;
  logic       m_active = 1'b0;
  int         m_n      = 0;
  logic [9:0] m_bits   = '1;
  logic       blk      = 1'b0;

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic nd, input logic [7:0] d, input logic b);
    logic nx_tx, nx_busy;
    @(posedge clk);
    #1;
    rst = r; new_data = nd; data = d; block = b;
    @(negedge clk);
    check_eq("tx", tx, m_tx);
    check_eq("busy", busy, m_busy);
    if (r) begin
      nx_tx = 1'b1; nx_busy = 1'b0; m_active = 1'b0;
    end else if (m_active) begin
      if (cyc == m_n + 10*CPB) begin
        nx_tx = 1'b1; nx_busy = m_s; m_active = 1'b0;
      end else begin
        nx_tx = m_bits[(cyc - m_n) / CPB]; nx_busy = 1'b1;
      end
    end else if (!m_busy && !m_s && nd) begin
      m_n = cyc; m_bits = {1'b1, d, 1'b0}; m_active = 1'b1;
      nx_tx = 1'b0; nx_busy = 1'b1;
    end else begin
      nx_tx = 1'b1; nx_busy = m_s;
    end
    if (r) begin
      m_s = 1'b0; m_meta = 1'b0;
    end else begin
      m_s = m_meta; m_meta = b;
    end
    m_tx = nx_tx; m_busy = nx_busy;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom), blk);
  endtask

  task automatic strobe_when_free(input logic [7:0] d);
    for (int i = 0; i < 20*CPB + 10; i++) begin
      if (!m_busy && !m_s) begin
        step(1'b0, 1'b1, d, blk);
        return;
      end
      step(1'b0, 1'b0, 8'($urandom), blk);
    end
    n_vec++;
    n_err++;
    $display("FAIL strobe_timeout cyc=%0d got=busy expected=free", cyc);
  endtask

  initial begin
    rst = 1'b1; new_data = 1'b0; data = 8'h00; block = 1'b0;
    repeat (2) @(posedge clk);

    idle(3);
    strobe_when_free(8'hA5);
    idle(45);

    strobe_when_free(8'h00);
    strobe_when_free(8'hFF);
    idle(45);

    strobe_when_free(8'h3C);
    idle(3);
    step(1'b0, 1'b1, 8'h81, blk);
    idle(45);

    blk = 1'b1;
    idle(6);
    step(1'b0, 1'b1, 8'h55, blk);
    idle(4);
    blk = 1'b0;
    idle(5);
    strobe_when_free(8'h55);
    idle(45);

    strobe_when_free(8'hF0);
    idle(4*CPB + 1);
    step(1'b1, 1'b1, 8'h12, blk);
    idle(5);
    strobe_when_free(8'h0F);
    idle(45);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) blk = ~blk;
      step(($urandom_range(0, 799) == 0), ($urandom_range(0, 5) == 0), 8'($urandom), blk);
    end
    blk = 1'b0;
    idle(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
